// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the fetch stage and its IF/ID register.
//   fetch_state_t    : fetch FSM states
//   fetch_pkt_t      : {instr, pc} pair carried through the skid and into IF/ID
//   NOP_INSTR        : addi x0,x0,0, inserted on bubbles and flushes
//   DEFAULT_RESET_PC : default PC after reset (word aligned)
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_pkt_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Update priority: flush > stall (hold) > load > bubble.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : redirect; output becomes a NOP bubble even when stalled
//   stall_i       : decode cannot accept; hold all outputs
//   load_i, pkt_i : new instruction and its PC
//   instr_o, pc_o, pcplus4_o, valid_o : decode-side outputs
module if_id_reg
    import core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  fetch_pkt_t  pkt_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_o <= NOP_INSTR;
            pc_o    <= 32'h0;
            valid_o <= 1'b0;
        end else if (flush_i) begin
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end else if (stall_i) begin
            // hold
        end else if (load_i) begin
            instr_o <= pkt_i.instr;
            pc_o    <= pkt_i.pc;
            valid_o <= 1'b1;
        end else begin
            // bubble keeps pc_o so decode still sees a coherent PC
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end
    end

    // wraps mod 2^32 naturally
    assign pcplus4_o = pc_o + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch with single-outstanding imem handshake,
// skid register for a response that arrives under stall, and kill flag for
// a response that was in flight when a redirect happened.
// Optional macro FETCH_MISALIGN_CHECK_EN: registers a one-cycle misalign_o
// pulse on a redirect whose target is not word aligned (otherwise tied 0).
//   clk_i, rst_ni          : clock, async active-low reset
//   stall_i                : decode stall from hazard unit
//   redirect_i, target_i   : taken branch/jump from execute
//   imem_req_o/addr_o      : request out (addr = current PC)
//   imem_gnt_i, imem_rvalid_i, imem_rdata_i : memory handshake in
//   instr_o, pc_o, pcplus4_o, valid_o : IF/ID outputs
//   misalign_o             : misaligned-redirect pulse
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o,
    output logic        misalign_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;     // next address to request
    logic [31:0]  ipc_q, ipc_d;   // address of the request in flight
    logic         kill_q, kill_d;
    fetch_pkt_t   skid_q, skid_d;
    logic         ifid_load;
    fetch_pkt_t   ifid_pkt;
    logic [31:0]  tgt_aligned;
    logic         grant;

    assign tgt_aligned = {target_i[31:2], 2'b00};

    // In WAIT the next request goes out in the same cycle the response lands,
    // as long as that response will actually be consumed.
    assign imem_req_o  = !redirect_i &&
                         ((state_q == REQ) ||
                          (state_q == WAIT && imem_rvalid_i && !stall_i && !kill_q));
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ipc_d     = ipc_q;
        kill_d    = kill_q;
        skid_d    = skid_q;
        ifid_load = 1'b0;
        ifid_pkt  = skid_q;

        // grant and redirect are exclusive because redirect masks the request
        if (grant) begin
            pc_d  = pc_q + 32'd4;
            ipc_d = pc_q;
        end
        if (redirect_i) pc_d = tgt_aligned;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (grant) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_q || redirect_i) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (stall_i) begin
                        skid_d  = '{instr: imem_rdata_i, pc: ipc_q};
                        state_d = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        ifid_pkt  = '{instr: imem_rdata_i, pc: ipc_q};
                        state_d   = grant ? WAIT : REQ;
                    end
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    state_d = REQ;
                end else if (!stall_i) begin
                    ifid_load = 1'b1;
                    state_d   = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= RESET_PC;
            kill_q  <= 1'b0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            kill_q  <= kill_d;
            skid_q  <= skid_d;
        end
    end

    if_id_reg u_if_id (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (redirect_i),
        .stall_i   (stall_i),
        .load_i    (ifid_load),
        .pkt_i     (ifid_pkt),
        .instr_o   (instr_o),
        .pc_o      (pc_o),
        .pcplus4_o (pcplus4_o),
        .valid_o   (valid_o)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mis_q <= 1'b0;
        else         mis_q <= redirect_i && (target_i[1:0] != 2'b00);
    end
    assign misalign_o = mis_q;
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^target_i[1:0];
    assign misalign_o     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage. A memory responder with
// random grant/latency serves words from a fixed address hash; the reference
// model is the expected instruction stream (sequential PCs, restarted at the
// aligned target on every redirect) kept in a queue. A monitor pops the queue
// whenever the IF/ID register delivers a new instruction.
module tb_fetch_stage;
    import core_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i, redirect_i;
    logic [31:0] target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o, pc_o, pcplus4_o;
    logic        valid_o, misalign_o;

    always #5 clk_i = ~clk_i;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .target_i      (target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pcplus4_o     (pcplus4_o),
        .valid_o       (valid_o),
        .misalign_o    (misalign_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          deliveries = 0;
    logic [31:0] exp_q[$];
    bit          rand_en = 1'b0;
    bit          zero_wait = 1'b1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_req",      {31'h0, imem_req_o}, 32'h0);
        chk("rst_addr",     imem_addr_o, RPC);
        chk("rst_instr",    instr_o, NOP_INSTR);
        chk("rst_pc",       pc_o, 32'h0);
        chk("rst_pcplus4",  pcplus4_o, 32'h4);
        chk("rst_valid",    {31'h0, valid_o}, 32'h0);
        chk("rst_misalign", {31'h0, misalign_o}, 32'h0);
    endtask

    // stimulus + memory responder, driven at negedge
    initial begin
        stall_i = 1'b0; redirect_i = 1'b0; target_i = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        forever begin
            @(negedge clk_i);
            imem_gnt_i = 1'b0;
            if (!rst_ni) begin
                pend = 1'b0; imem_rvalid_i = 1'b0;
                stall_i = 1'b0; redirect_i = 1'b0;
                continue;
            end
            if (pend && pend_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = $urandom;
                if (pend) pend_cnt--;
            end
            if (rand_en) begin
                stall_i    = ($urandom_range(0, 99) < 25);
                redirect_i = ($urandom_range(0, 99) < 6);
                case ($urandom_range(0, 3))
                    0:       target_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    1:       target_i = 32'($urandom_range(0, 255));
                    default: target_i = $urandom;
                endcase
                if (redirect_i) begin
                    exp_q.delete();
                    exp_q.push_back({target_i[31:2], 2'b00});
                end
            end
            #1;
            if (redirect_i) chk("req_during_redirect", {31'h0, imem_req_o}, 32'h0);
            if (imem_req_o && (zero_wait || $urandom_range(0, 99) < 65)) begin
                imem_gnt_i = 1'b1;
                chk("single_outstanding", {31'h0, pend}, 32'h0);
                pend      = 1'b1;
                pend_addr = imem_addr_o;
                pend_cnt  = zero_wait ? 0 : int'($urandom_range(0, 2));
            end
        end
    end

    // monitor / scoreboard, samples 1 time unit after each rising edge
    initial begin
        logic [31:0] p_instr, p_pc, p_pc4, e;
        logic        p_vld, exp_mis;
        p_instr = NOP_INSTR; p_pc = 32'h0; p_pc4 = 32'h4; p_vld = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_ni) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                exp_mis = redirect_i && (target_i[1:0] != 2'b00);
`else
                exp_mis = 1'b0;
`endif
                chk("misalign", {31'h0, misalign_o}, {31'h0, exp_mis});
                if (redirect_i) begin
                    chk("flush_valid", {31'h0, valid_o}, 32'h0);
                    chk("flush_instr", instr_o, NOP_INSTR);
                end else if (stall_i) begin
                    chk("hold_valid",   {31'h0, valid_o}, {31'h0, p_vld});
                    chk("hold_instr",   instr_o, p_instr);
                    chk("hold_pc",      pc_o, p_pc);
                    chk("hold_pcplus4", pcplus4_o, p_pc4);
                end else if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL stream: delivery pc %h with nothing expected", pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pc",      pc_o, e);
                        chk("instr",   instr_o, mem_word(e));
                        chk("pcplus4", pcplus4_o, e + 32'd4);
                        exp_q.push_back(e + 32'd4);
                        deliveries++;
                    end
                end else begin
                    chk("bubble_instr", instr_o, NOP_INSTR);
                    chk("bubble_pc",    pc_o, p_pc);
                end
            end
            p_instr = instr_o; p_pc = pc_o; p_pc4 = pcplus4_o; p_vld = valid_o;
        end
    end

    initial begin
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_reset();
        exp_q.push_back(RPC);
        rst_ni = 1'b1;

        // zero-wait memory: request in cycle 1, first instruction in cycle 3
        @(posedge clk_i); #1;
        chk("first_req",  {31'h0, imem_req_o}, 32'h1);
        chk("first_addr", imem_addr_o, RPC);
        repeat (2) @(posedge clk_i); #1;
        chk("first_valid",   {31'h0, valid_o}, 32'h1);
        chk("first_instr",   instr_o, 32'h0050_0093);
        chk("first_pc",      pc_o, 32'h0);
        chk("first_pcplus4", pcplus4_o, 32'h4);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            chk("b2b_valid", {31'h0, valid_o}, 32'h1);
        end

        // random stall / redirect / memory latency
        zero_wait = 1'b0;
        rand_en   = 1'b1;
        repeat (1500) @(posedge clk_i);

        // asynchronous reset in the middle of traffic
        #3;
        rst_ni = 1'b0;
        #1;
        chk_reset();
        exp_q.delete();
        exp_q.push_back(RPC);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (1000) @(posedge clk_i);

        chk("liveness", {31'h0, deliveries > 150}, 32'h1);
        rand_en = 1'b0;
        @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 32-bit RISC-V core. It owns the PC and issues word requests to instruction memory over a single-outstanding req/gnt/rvalid handshake. It presents each fetched instruction, with its PC and PC+4, to the decode stage, where instr_o[31:7] drives the immediate sign-extender and the register-file address fields. It honours stall from the hazard unit and redirect (taken branch or jump) from execute.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset; must be word-aligned.
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- stall_i  in  1  decode cannot accept; the IF/ID outputs hold.
- redirect_i  in  1  taken branch or jump from execute.
- target_i  in  32  redirect target PC.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  32  request word address; equals the current PC.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid; the earliest response arrives one cycle after grant.
- imem_rdata_i  in  32  instruction word.
- instr_o  out  32  IF/ID instruction.
- pc_o  out  32  PC of instr_o.
- pcplus4_o  out  32  pc_o + 4.
- valid_o  out  1  instr_o is a real instruction; 0 means bubble.
- misalign_o  out  1  one-cycle pulse on a misaligned redirect (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, HOLD. A skid register holds {instr, pc}. A kill flag marks an in-flight response to discard.
- imem_req_o = 1 in REQ. It is also 1 in WAIT when imem_rvalid_i & !stall_i & !kill, which gives back-to-back fetch. It is forced to 0 whenever redirect_i = 1.
- On grant, PC advances to PC+4 with wrap modulo 2^32. pcplus4_o is computed mod 2^32.
- IDLE → REQ unconditionally. IDLE is entered only from reset.
- REQ:
  - On grant → WAIT.
  - On redirect, PC ← target and the state stays REQ.
- WAIT, redirect without rvalid: PC ← target, kill ← 1, state stays WAIT.
- WAIT, rvalid with kill or with redirect: discard the data, clear kill, go to REQ, and apply the redirect target if one is present.
- WAIT, rvalid with stall: data and its PC go to the skid register; → HOLD.
- WAIT, rvalid with no stall: load IF/ID with valid_o = 1.
  - If the back-to-back request is granted in the same cycle → WAIT.
  - Otherwise → REQ.
- HOLD:
  - On redirect: drop the skid, PC ← target, → REQ.
  - When stall is low: load the skid into IF/ID, → REQ.
- IF/ID update priority:
  1. redirect flushes: valid_o ← 0 and instr_o ← 32'h0000_0013 (NOP). This applies even when stall is high.
  2. stall holds all outputs.
  3. A new instruction loads.
  4. Otherwise a bubble is inserted: valid_o ← 0, instr_o ← NOP, pc_o unchanged.
- Reset values: imem_req_o 0, imem_addr_o RESET_PC, instr_o NOP, pc_o 0, pcplus4_o 4, valid_o 0, misalign_o 0. Internally, PC = RESET_PC, kill = 0, state = IDLE.
- Reset asserted mid-request clears kill and the skid register. Any later rvalid for that request is ignored while in IDLE/REQ.

## Timing
- Zero-wait memory: a grant in cycle N, with rvalid in N+1, gives instr_o valid from N+2. Sustained throughput is 1 instruction per cycle.
- Redirect in cycle N: the first request to target_i is in N+1, and the target instruction appears on instr_o at N+3 at the earliest.
- rvalid while in REQ or IDLE is ignored. The memory is required never to do this.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with target_i[1:0] ≠ 0 pulses misalign_o for the cycle after the redirect.
  - The PC loads {target_i[31:2], 2'b00}.
- Undefined: target_i[1:0] is silently cleared and misalign_o is tied to 0.

## Structure
- Shared package core_pkg holds:
  - fetch_state_t enum.
  - NOP_INSTR = 32'h0000_0013.
  - The default RESET_PC.
- One sub-module, if_id_reg, holds the output register and its flush/stall/load/bubble priority. fetch_stage contains the FSM, PC, skid register and kill logic.

## Test plan
- Reset release, RESET_PC = 0, zero-wait memory returning 0x00500093 at address 0: imem_addr_o = 0 in cycle 1. instr_o = 0x00500093, pc_o = 0, pcplus4_o = 4, valid_o = 1 in cycle 3. PCs 0,4,8,… are then delivered back-to-back.
- stall_i high for 3 cycles while rvalid returns the word for 0x8: outputs hold the 0x4 instruction and no new request is issued. After stall drops, the 0x8 instruction appears the next cycle.
- redirect_i with target 0x100 while in WAIT with rvalid delayed 2 cycles: the late response is discarded and valid_o = 0 with NOP. The next imem_addr_o is 0x100.
- redirect_i and stall_i high in the same cycle: outputs flush to NOP with valid_o = 0. The PC takes target_i.
- PC at 0xFFFF_FFFC is fetched: pcplus4_o = 0 and the next request address is 0.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 gives misalign_o = 1 for one cycle and imem_addr_o = 0x100.
